// File: rtl/expr_gen_if.sv
// Character stream handshake between expr_gen and its consumer.
interface expr_gen_if;
    logic [7:0] out_char;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (output out_char, output out_valid, output out_last, input  out_ready);
    modport slave  (input  out_char, input  out_valid, input  out_last, output out_ready);
endinterface

// File: rtl/expr_gen.sv
// Pseudo-random generator of well-formed arithmetic expressions over a valid/ready stream.
// Optional EXPR_GEN_ERR_INJECT_EN adds err_inj: a stray "+" before the terminator.
module expr_gen #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [7:0]  TERM = 8'h3B
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [7:0]  len,
    input  logic [15:0] seed,
    output logic        busy,
`ifdef EXPR_GEN_ERR_INJECT_EN
    input  logic        err_inj,
`endif
    expr_gen_if.master  o
);
    typedef enum logic [2:0] {IDLE, START, TOP_OP, TOP_NUM, LP, IN_NUM, IN_OP, DONE} state_t;
    typedef struct packed {
        logic [7:0] ch;
        logic       last;
        state_t     nxt;
    } emit_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [7:0] digit(input logic [3:0] n);
        return 8'h30 + {4'd0, (n < 4'd10) ? n : n - 4'd10};
    endfunction

    // Character produced in state st; nxt is the state that picks the following character.
    function automatic emit_t pick(input state_t st, input logic [6:0] v,
                                   input logic [9:0] c, input logic [9:0] l, input logic inj);
        emit_t e;
        e.ch   = digit(v[3:0]);
        e.last = 1'b0;
        e.nxt  = TOP_NUM;
        case (st)
            START, TOP_OP: if (c + 10'd3 <= l && v[5]) begin
                e.ch  = 8'h28;
                e.nxt = LP;
            end
            TOP_NUM: if (c + 10'd2 > l) begin
                if (inj) begin
                    e.ch  = 8'h2B;
                    e.nxt = DONE;
                end else begin
                    e.ch   = TERM;
                    e.last = 1'b1;
                    e.nxt  = IDLE;
                end
            end else begin
                e.ch  = v[4] ? 8'h2A : 8'h2B;
                e.nxt = TOP_OP;
            end
            LP, IN_OP: e.nxt = IN_NUM;
            IN_NUM: if (c + 10'd3 > l || v[6]) begin
                e.ch  = 8'h29;
                e.nxt = TOP_NUM;
            end else begin
                e.ch  = v[4] ? 8'h2A : 8'h2B;
                e.nxt = IN_OP;
            end
            default: begin
                e.ch   = TERM;
                e.last = 1'b1;
                e.nxt  = IDLE;
            end
        endcase
        return e;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  char_q, char_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        inj_q, inj_d;
    logic        inj_start;
    logic [15:0] seed_eff, lfsr_nx;
    logic [7:0]  len_eff;
    emit_t       em;

`ifdef EXPR_GEN_ERR_INJECT_EN
    assign inj_start = err_inj;
`else
    assign inj_start = 1'b0;
`endif

    // state_q holds the state that will pick the character after the one on out_char.
    always_comb begin
        seed_eff = (seed == 16'd0) ? SEED : seed;
        len_eff  = (len == 8'd0) ? 8'd1 : len;
        lfsr_nx  = lfsr_step(lfsr_q);
        if (busy_q)
            em = pick(state_q, lfsr_nx[6:0], cnt_q + 10'd1, {2'b00, len_q}, inj_q);
        else
            em = pick(START, seed_eff[6:0], 10'd0, {2'b00, len_eff}, inj_start);

        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        char_d  = char_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        last_d  = last_q;
        inj_d   = inj_q;

        if (!busy_q) begin
            if (start) begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
                len_d   = len_eff;
                lfsr_d  = seed_eff;
                cnt_d   = 10'd0;
                inj_d   = inj_start;
                char_d  = em.ch;
                last_d  = em.last;
                state_d = em.nxt;
            end
        end else if (valid_q && o.out_ready) begin
            lfsr_d = lfsr_nx;
            if (last_q) begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = IDLE;
            end else begin
                cnt_d   = cnt_q + 10'd1;
                char_d  = em.ch;
                last_d  = em.last;
                state_d = em.nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= 10'd0;
            len_q   <= 8'd0;
            char_q  <= 8'h00;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            inj_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            char_q  <= char_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            inj_q   <= inj_d;
        end
    end

    assign busy        = busy_q;
    assign o.out_char  = char_q;
    assign o.out_valid = valid_q;
    assign o.out_last  = last_q;
endmodule

// File: tb/tb_expr_gen.sv
// Randomized bench for expr_gen: spec-level generator model plus a grammar recognizer.
module tb_expr_gen;
    typedef logic [7:0] ch_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [7:0]  len_i;
    logic [15:0] seed_i;
    logic        busy;
    logic        err_inj_i;
    int          n_chk = 0;
    int          n_fail = 0;

    expr_gen_if bus();

    expr_gen dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .len   (len_i),
        .seed  (seed_i),
        .busy  (busy),
`ifdef EXPR_GEN_ERR_INJECT_EN
        .err_inj (err_inj_i),
`endif
        .o     (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Expected stream straight from the grammar-building rules.
    function automatic void model(input logic [15:0] sd, input int l_in, input bit inj, output ch_t s[$]);
        logic [15:0] lf = (sd == 16'd0) ? 16'hACE1 : sd;
        int  l = (l_in == 0) ? 1 : l_in;
        int  c = 0;
        bit  in_par = 0, need_opnd = 1, fin = 0;
        int  d;
        ch_t ch;
        s.delete();
        while (!fin) begin
            d  = int'(lf[3:0]);
            if (d >= 10) d -= 10;
            ch = 8'h30 + ch_t'(d);
            if (!in_par) begin
                if (need_opnd) begin
                    if (c + 3 <= l && lf[5]) begin ch = "("; in_par = 1; end
                    else need_opnd = 0;
                end else if (c + 2 > l) fin = 1;
                else begin ch = lf[4] ? "*" : "+"; need_opnd = 1; end
            end else begin
                if (need_opnd) need_opnd = 0;
                else if (c + 3 > l || lf[6]) begin ch = ")"; in_par = 0; end
                else begin ch = lf[4] ? "*" : "+"; need_opnd = 1; end
            end
            if (!fin) begin
                s.push_back(ch);
                c++;
                lf = step(lf);
            end
        end
        if (inj) s.push_back("+");
        s.push_back(8'h3B);
    endfunction

    function automatic bit is_dig(input ch_t c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    function automatic bit is_op(input ch_t c);
        return c == 8'h2B || c == 8'h2A;
    endfunction

    function automatic bit accept(input ch_t s[$]);
        int n = s.size();
        int i = 0;
        bit ok = 1, more = 1;
        while (ok && more) begin
            if (i < n && is_dig(s[i])) i++;
            else if (i < n && s[i] == 8'h28) begin
                i++;
                if (i < n && is_dig(s[i])) i++; else ok = 0;
                while (ok && i < n && is_op(s[i])) begin
                    i++;
                    if (i < n && is_dig(s[i])) i++; else ok = 0;
                end
                if (ok && i < n && s[i] == 8'h29) i++; else ok = 0;
            end else ok = 0;
            if (ok && i < n && is_op(s[i])) i++; else more = 0;
        end
        return ok && n > 0 && i == n - 1 && s[n-1] == 8'h3B;
    endfunction

    // mode 0: ready always high, 1: random ready, 2: stall the first character 5 cycles
    task automatic run_expr(input logic [15:0] sd, input logic [7:0] ln, input bit inj,
                            input int mode, input bit hammer,
                            output ch_t got[$], output logic [15:0] lfs[$]);
        int  cyc = 0;
        int  stall = 0;
        bit  done = 0;
        logic r;
        got.delete();
        lfs.delete();
        @(negedge clk);
        start = 1; len_i = ln; seed_i = sd; err_inj_i = inj;
        @(negedge clk);
        start = hammer;
        chk("busy_up", busy, 1);
        chk("valid_up", bus.out_valid, 1);
        while (!done && cyc < 2000) begin
            if (hammer) begin seed_i = 16'($urandom); len_i = 8'($urandom); end
            case (mode)
                0: r = 1;
                1: r = ($urandom_range(0, 3) != 0);
                default: begin
                    r = 1;
                    if (got.size() == 0 && stall < 5) begin
                        r = 0;
                        stall++;
                        chk("hold_char", bus.out_char, 8'h28);
                        chk("hold_valid", bus.out_valid, 1);
                    end
                end
            endcase
            bus.out_ready = r;
            if (bus.out_valid && r) begin
                got.push_back(bus.out_char);
                lfs.push_back(dut.lfsr_q);
                chk("last_flag", bus.out_last, bus.out_char == 8'h3B);
                if (bus.out_last) begin done = 1; start = 0; end
            end
            @(negedge clk);
            cyc++;
        end
        start = 0;
        if (!done) chk("timeout", 0, 1);
        chk("busy_fall", busy, 0);
        chk("valid_fall", bus.out_valid, 0);
    endtask

    task automatic cmp_stream(input string tag, input ch_t got[$], input ch_t exp[$]);
        chk({tag, "_n"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk(tag, got[i], exp[i]);
    endtask

    initial begin
        ch_t got[$], exp[$];
        logic [15:0] lfs[$];
        logic [15:0] sd;
        logic [7:0]  ln;
        bit inj;
        clr = 1; start = 0; len_i = 0; seed_i = 0; err_inj_i = 0; bus.out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_char", bus.out_char, 0);
        clr = 0;
        repeat (2) @(negedge clk);
        chk("idle_valid", bus.out_valid, 0);

        run_expr(16'd0, 8'd1, 0, 0, 0, got, lfs);
        exp = '{8'h31, 8'h3B};
        cmp_stream("len1", got, exp);
        run_expr(16'd0, 8'd0, 0, 0, 0, got, lfs);
        cmp_stream("len0", got, exp);

        run_expr(16'd0, 8'd3, 0, 0, 0, got, lfs);
        exp = '{8'h28, 8'h30, 8'h29, 8'h3B};
        cmp_stream("len3", got, exp);
        if (lfs.size() >= 3) begin
            chk("lfsr0", lfs[0], 16'hACE1);
            chk("lfsr1", lfs[1], 16'hE270);
            chk("lfsr2", lfs[2], 16'h7138);
        end else chk("lfsr_cnt", lfs.size(), 3);

        run_expr(16'd0, 8'd3, 0, 2, 0, got, lfs);
        cmp_stream("stall", got, exp);

        sd = 16'h1234; ln = 8'd40;
        run_expr(sd, ln, 0, 1, 1, got, lfs);
        model(sd, int'(ln), 0, exp);
        cmp_stream("hammer", got, exp);

        // abort mid-expression
        @(negedge clk);
        start = 1; len_i = 8'd50; seed_i = 16'h7777; bus.out_ready = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        clr = 1;
        @(negedge clk);
        chk("clr_busy", busy, 0);
        chk("clr_valid", bus.out_valid, 0);
        chk("clr_last", bus.out_last, 0);
        chk("clr_char", bus.out_char, 0);
        chk("clr_lfsr", dut.lfsr_q, 16'hACE1);
        clr = 0;

        for (int k = 0; k < 1000; k++) begin
            sd  = 16'($urandom);
            ln  = 8'($urandom_range(1, 60));
`ifdef EXPR_GEN_ERR_INJECT_EN
            inj = 1'($urandom_range(0, 1));
`else
            inj = 0;
`endif
            run_expr(sd, ln, inj, 1, 0, got, lfs);
            model(sd, int'(ln), inj, exp);
            cmp_stream("rand", got, exp);
            chk("accept", accept(got), !inj);
            chk("len_bound", (got.size() - 1) <= int'(ln) + int'(inj), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/expr_gen.md
# expr_gen

Pseudo-random generator of well-formed arithmetic-expression character streams, the transmit-side counterpart to the expression-recognizer FSMs. The block emits ASCII characters over a valid/ready handshake, one character per accepted transfer, and follows the grammar the recognizers accept: `expr := term (op term)*`, `term := digit | '(' digit (op digit)* ')'`, `op := '+' | '*'`, with one nesting level. A terminator character closes every expression. It is the stimulus source for recognizer benches and for serial-parser test harnesses.

## Interface
- `SEED`, 16'hACE1, LFSR load value used when the `seed` port is zero
- `TERM`, 8'h3B (`;`), terminator character, always outside the grammar alphabet
- `clk`  in  1  clock; all logic on the rising edge
- `clr`  in  1  reset, synchronous, active-high
- `start`  in  1  begin one expression; sampled only while `busy`=0
- `len`  in  8  character budget, terminator excluded; 0 is treated as 1
- `seed`  in  16  LFSR load value at `start`; 0 selects `SEED`
- `busy`  out  1  expression in progress
- `out_char`  out  8  ASCII character
- `out_valid`  out  1  `out_char` is valid
- `out_ready`  in  1  consumer accepts `out_char`
- `out_last`  out  1  `out_char` is the terminator

## Operation
- Reset values: `busy`=0, `out_valid`=0, `out_last`=0, `out_char`=8'h00, state IDLE, `cnt`=0, `lfsr`=`SEED`.
- `start` in IDLE does the following:
  - latches `len`, with 0 replaced by 1
  - loads `lfsr`
  - clears `cnt`
  - enters START
- `start` while busy is ignored.
- The LFSR is a 16-bit Galois LFSR. When `lfsr[0]`=1, next = (`lfsr`>>1)^16'hB400; otherwise next = `lfsr`>>1. It advances once per handshake (`out_valid & out_ready`).
- Every character-selection decision uses the current `lfsr` value, before it advances.
- `cnt` increments on each non-terminator handshake.
- Digit = "0" + d, where d = `lfsr[3:0]` if that value is below 10, otherwise `lfsr[3:0]`−10.
- Op = `lfsr[4]` ? "*" : "+".
- States and the character each one emits (`C` = `cnt`, `L` = latched `len`):
  - START / TOP_OP (operand expected): if `C`+3 ≤ `L` and `lfsr[5]`=1, emit "(" and go to LP. Otherwise emit a digit and go to TOP_NUM.
  - TOP_NUM: if `C`+2 > `L`, emit `TERM` with `out_last`=1 and go to DONE. Otherwise emit an op and go to TOP_OP.
  - LP: emit a digit and go to IN_NUM.
  - IN_NUM: if `C`+3 > `L` or `lfsr[6]`=1, emit ")" and go to TOP_NUM. Otherwise emit an op and go to IN_OP.
  - IN_OP: emit a digit and go to IN_NUM.
  - DONE: once the terminator handshake completes, clear `out_valid` and `busy` and return to IDLE.
- Guarantees:
  - emitted length (terminator excluded) ≤ `L`
  - the stream always ends on an operand or ")"
  - parentheses are always balanced
- `clr` in any state aborts the expression immediately and restores the reset values. No terminator is emitted.

## Timing
- Latency: `start` sampled at edge t gives `busy`=1 and `out_valid`=1 with the first character after edge t.
- Throughput: one character per cycle while `out_ready`=1, with no bubbles.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_char`, `out_last`, `lfsr`, `cnt` and the state hold.
- After the terminator handshake at edge t, `busy`=0 after edge t. A new `start` is accepted at edge t+1 or later.

## Configuration
- Macro `EXPR_GEN_ERR_INJECT_EN`.
- Defined:
  - adds port `err_inj` (in, 1), latched at `start`
  - when the latched value is 1, a single "+" is emitted in DONE before `TERM`; the stream is then invalid with length ≤ `L`+1
  - `cnt` is not checked for this extra character
- Undefined: the port is absent and no injection logic exists.

## Test plan
- Reset, then idle: `busy`=0, `out_valid`=0, `out_last`=0, `out_char`=8'h00. Asserting `clr` mid-expression returns all of these values on the next cycle.
- `seed`=0, `len`=1, `out_ready`=1 → stream "1;". `out_last`=1 only on ";". `busy` falls the cycle after.
- `seed`=0, `len`=3 → stream "(0);", with `lfsr` sequence 16'hACE1, 16'hE270, 16'h7138.
- `len`=3, `out_ready` held low for 5 cycles after the first character → "(" stable for all 5 cycles. The stream is still "(0);" and no character is lost or duplicated.
- Assert `start` while busy → ignored; the current stream is unaffected.
- 1000 random seeds and `len` values in 1..60, streams checked against a golden recognizer model:
  - every stream is accepted
  - length ≤ `len`
  - with `EXPR_GEN_ERR_INJECT_EN` defined and `err_inj`=1, every stream is rejected
